video_timing: RTL and testbench
===============================

# video_timing

Generates the raster timing that drives the tile generator, sprite engine and video DAC: a horizontal half-pixel counter `htiming`, a vertical line counter, the flip-adjusted `vtiming_f`, composite blanking `cmpblk`, sync pulses and the vertical-blank NMI to the Z80. It sits directly upstream of the tile generator. Every video stage derives its fetch and shift schedule from these counters, so all outputs are registered and mutually coincident.

## Interface
- `H_TOTAL`, 768: `htiming` counts per line. 2 counts per pixel, 384 pixel clocks.
- `H_ACTIVE`, 512: `htiming` 0..511 is visible, so `htiming[9]`=0 exactly in active video.
- `HS_START`, 608 / `HS_END`, 672: `hsync_n` is low for `htiming` in [HS_START, HS_END).
- `V_TOTAL`, 264: lines per frame.
- `V_ACT_START`, 16 / `V_ACT_END`, 240: visible lines are [16, 240).
- `VS_START`, 248 / `VS_END`, 256: `vsync_n` is low for lines in [VS_START, VS_END).
- `clk`, in, 1: system video clock, one `htiming` count per cycle.
- `rst`, in, 1: synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `flip_ena`, in, 1: screen flip request from vidctrl.
- `nmi_ena`, in, 1: NMI mask from vidctrl. 1 = enabled; 0 = masked and clears any pending NMI.
- `htiming`, out, 10: horizontal count, 0..H_TOTAL-1.
- `vtiming`, out, 9: vertical line count, 0..V_TOTAL-1.
- `vtiming_f`, out, 8: `vtiming[7:0]` XOR {8{flip_lat}}.
- `flip_lat`, out, 1: frame-latched flip, for downstream stages.
- `hblank`, `vblank`, `cmpblk`, out, 1 each: blanking. `cmpblk` = `hblank` | `vblank`.
- `hsync_n`, `vsync_n`, out, 1 each: active-low syncs.
- `line_start`, `frame_start`, out, 1 each: single-cycle pulses.
- `nmi_n`, out, 1: active-low vertical-blank interrupt to the CPU.

## Operation
- **Horizontal counter:** `htiming` increments every cycle. At H_TOTAL-1 it wraps to 0, and the vertical counter advances in the same cycle.
- **Vertical counter:** `vtiming` wraps from V_TOTAL-1 to 0. No other load paths exist.
- **Decode:** all decoded outputs are registered from the next-state counter values, so each output is consistent with the counter value shown in the same cycle. There is no one-cycle skew.
  - `hblank` = (`htiming` >= H_ACTIVE).
  - `vblank` = (`vtiming` < V_ACT_START) | (`vtiming` >= V_ACT_END).
- **Pulses:** `line_start` = 1 iff `htiming`==0. `frame_start` = 1 iff `htiming`==0 and `vtiming`==0.
- **Flip latch:** `flip_lat` samples `flip_ena` only on the cycle that produces `frame_start`. A mid-frame change of `flip_ena` has no effect until the next frame.
- **NMI state machine,** two states:
  - IDLE → PEND on the vblank rising event (`htiming`==0, `vtiming`==V_ACT_END) when `nmi_ena`=1.
  - PEND → IDLE when `nmi_ena`=0.
  - `nmi_n` = 0 in PEND.
  - NMI is edge-based: setting `nmi_ena` to 1 after the vblank rise, in the same frame, does not assert `nmi_n`.
  - The CPU acknowledges by writing the mask to 0.
- **Simultaneous events:**
  - `nmi_ena`=0 on the vblank-rise cycle: no NMI.
  - `nmi_ena` falling while in PEND on a later vblank-rise cycle: the clear wins, and the state is IDLE.
- **Parameters:** the block assumes the parameters are internally consistent (H_ACTIVE < HS_START < HS_END <= H_TOTAL, and similarly for the vertical set). It contains no runtime checks.

## Timing
- **Reset values:** `rst` held high gives `htiming`=0, `vtiming`=0, `flip_lat`=0, `vtiming_f`=0, `hblank`=0, `vblank`=1, `cmpblk`=1, `hsync_n`=1, `vsync_n`=1, `line_start`=0, `frame_start`=0, `nmi_n`=1, NMI state IDLE.
- **First cycle after release:** the counters read 0→1 on the first cycle after `rst` deasserts. The first `line_start` is at the wrap, H_TOTAL cycles later.
- **Reset mid-frame:** returns all outputs to the reset values on the next edge and drops any pending NMI.
- **Latency from inputs:**
  - `flip_ena` affects `vtiming_f` at most V_TOTAL×H_TOTAL cycles later, always at a frame boundary.
  - `nmi_ena`=0 releases `nmi_n` one cycle after it is sampled.
- **Frame length:** H_TOTAL×V_TOTAL = 202752 cycles.

## Test plan
- **Reset and counting:** hold `rst` 3 cycles, then release. Check reset values. After 512 cycles, `htiming`=512 and `hblank`=1, `cmpblk`=1. After 768 cycles, `htiming`=0, `vtiming`=1, `line_start`=1.
- **Sync windows:** over one line, `hsync_n`=0 for exactly 64 cycles, starting at `htiming`=608. Over one frame, `vsync_n`=0 for exactly 8×768 cycles, starting at `vtiming`=248. `vblank` transitions 1→0 at line 16 and 0→1 at line 240.
- **Flip:** toggle `flip_ena` to 1 at line 100. `vtiming_f` still equals `vtiming[7:0]` through line 263. From `frame_start` onward, `vtiming_f`=0xFF at line 0 and 0xEF at line 16.
- **NMI:** with `nmi_ena`=1, `nmi_n` falls exactly at `vtiming`=240, `htiming`=0. Drive `nmi_ena`=0 at line 250; `nmi_n`=1 the next cycle. Set `nmi_ena`=1 at line 252; no reassertion until line 240 of the next frame.
- **Simultaneous:** drop `nmi_ena` on the exact vblank-rise cycle; `nmi_n` stays 1 for the whole frame.
- **Reset mid-operation:** assert `rst` at line 245 with NMI pending and `flip_lat`=1. The next cycle shows `nmi_n`=1, `flip_lat`=0, and both counters at 0.

Source files
------------

// File: rtl/video_timing.sv
// Raster timing generator: horizontal/vertical counters, blanking, syncs,
// frame-latched flip and the vertical-blank NMI, all registered and coincident.
module video_timing #(
    parameter int unsigned H_TOTAL     = 768,
    parameter int unsigned H_ACTIVE    = 512,
    parameter int unsigned HS_START    = 608,
    parameter int unsigned HS_END      = 672,
    parameter int unsigned V_TOTAL     = 264,
    parameter int unsigned V_ACT_START = 16,
    parameter int unsigned V_ACT_END   = 240,
    parameter int unsigned VS_START    = 248,
    parameter int unsigned VS_END      = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flip_ena,
    input  logic       nmi_ena,
    output logic [9:0] htiming,
    output logic [8:0] vtiming,
    output logic [7:0] vtiming_f,
    output logic       flip_lat,
    output logic       hblank,
    output logic       vblank,
    output logic       cmpblk,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       line_start,
    output logic       frame_start,
    output logic       nmi_n
);

    typedef enum logic {
        NMI_IDLE = 1'b0,
        NMI_PEND = 1'b1
    } nmi_state_t;

    logic [9:0] r_htiming;
    logic [8:0] r_vtiming;
    logic [7:0] r_vtiming_f;
    logic       r_flip_lat;
    logic       r_hblank;
    logic       r_vblank;
    logic       r_cmpblk;
    logic       r_hsync_n;
    logic       r_vsync_n;
    logic       r_line_start;
    logic       r_frame_start;
    nmi_state_t r_nmi_state;

    logic [9:0] w_h_next;
    logic [8:0] w_v_next;
    logic       w_h_wrap;
    logic       w_line;
    logic       w_frame;
    logic       w_flip_next;
    logic       w_vblank_rise;
    logic       w_hblank_next;
    logic       w_vblank_next;
    nmi_state_t w_nmi_next;

    // Decode works on the next-state counters so every registered output
    // lines up with the counter value it is shown alongside.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        w_h_wrap = (r_htiming == 10'(H_TOTAL - 1));
        w_h_next = w_h_wrap ? 10'd0 : r_htiming + 10'd1;
        w_v_next = r_vtiming;
        if (w_h_wrap) begin
            w_v_next = (r_vtiming == 9'(V_TOTAL - 1)) ? 9'd0 : r_vtiming + 9'd1;
        end
        w_line        = (w_h_next == 10'd0);
        w_frame       = w_line && (w_v_next == 9'd0);
        w_flip_next   = w_frame ? flip_ena : r_flip_lat;
        w_vblank_rise = w_line && (w_v_next == 9'(V_ACT_END));
        w_hblank_next = (w_h_next >= 10'(H_ACTIVE));
        w_vblank_next = (w_v_next < 9'(V_ACT_START)) || (w_v_next >= 9'(V_ACT_END));
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep all state updates simultaneous.
        if (rst) begin
            r_htiming     <= '0;
            r_vtiming     <= '0;
            r_vtiming_f   <= '0;
            r_flip_lat    <= 1'b0;
            r_hblank      <= 1'b0;
            r_vblank      <= 1'b1;
            r_cmpblk      <= 1'b1;
            r_hsync_n     <= 1'b1;
            r_vsync_n     <= 1'b1;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_htiming     <= w_h_next;
            r_vtiming     <= w_v_next;
            r_vtiming_f   <= w_v_next[7:0] ^ {8{w_flip_next}};
            r_flip_lat    <= w_flip_next;
            r_hblank      <= w_hblank_next;
            r_vblank      <= w_vblank_next;
            r_cmpblk      <= w_hblank_next || w_vblank_next;
            r_hsync_n     <= !((w_h_next >= 10'(HS_START)) && (w_h_next < 10'(HS_END)));
            r_vsync_n     <= !((w_v_next >= 9'(VS_START)) && (w_v_next < 9'(VS_END)));
            r_line_start  <= w_line;
            r_frame_start <= w_frame;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_nmi_state <= NMI_IDLE;
        end else begin
            r_nmi_state <= w_nmi_next;
        end
    end

    // A low mask always wins, even on the vblank-rise cycle itself.
    always_comb begin
        w_nmi_next = r_nmi_state;
        case (r_nmi_state)
            NMI_IDLE: if (nmi_ena && w_vblank_rise) w_nmi_next = NMI_PEND;
            NMI_PEND: if (!nmi_ena) w_nmi_next = NMI_IDLE;
            default:  w_nmi_next = NMI_IDLE;
        endcase
    end

    assign htiming     = r_htiming;
    assign vtiming     = r_vtiming;
    assign vtiming_f   = r_vtiming_f;
    assign flip_lat    = r_flip_lat;
    assign hblank      = r_hblank;
    assign vblank      = r_vblank;
    assign cmpblk      = r_cmpblk;
    assign hsync_n     = r_hsync_n;
    assign vsync_n     = r_vsync_n;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign nmi_n       = (r_nmi_state != NMI_PEND);

endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing: a full-size instance for line-level checks and a
// scaled instance for frame-level, flip, NMI and randomized checks.
module tb_video_timing;

    localparam int S_HT  = 24;
    localparam int S_HA  = 16;
    localparam int S_HSS = 19;
    localparam int S_HSE = 21;
    localparam int S_VT  = 20;
    localparam int S_VAS = 3;
    localparam int S_VAE = 15;
    localparam int S_VSS = 16;
    localparam int S_VSE = 18;
    localparam int S_FRAME = S_HT * S_VT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Full-size instance
    logic       rst_b = 1'b1;
    logic       flip_b = 1'b0;
    logic       nmi_b = 1'b0;
    logic [9:0] b_htiming;
    logic [8:0] b_vtiming;
    logic [7:0] b_vtiming_f;
    logic       b_flip_lat, b_hblank, b_vblank, b_cmpblk, b_hsync_n, b_vsync_n;
    logic       b_line_start, b_frame_start, b_nmi_n;

    video_timing u_big (
        .clk(clk), .rst(rst_b), .flip_ena(flip_b), .nmi_ena(nmi_b),
        .htiming(b_htiming), .vtiming(b_vtiming), .vtiming_f(b_vtiming_f),
        .flip_lat(b_flip_lat), .hblank(b_hblank), .vblank(b_vblank),
        .cmpblk(b_cmpblk), .hsync_n(b_hsync_n), .vsync_n(b_vsync_n),
        .line_start(b_line_start), .frame_start(b_frame_start), .nmi_n(b_nmi_n)
    );

    // Scaled instance
    logic       rst_s = 1'b1;
    logic       flip_s = 1'b0;
    logic       nmi_s = 1'b1;
    logic [9:0] s_htiming;
    logic [8:0] s_vtiming;
    logic [7:0] s_vtiming_f;
    logic       s_flip_lat, s_hblank, s_vblank, s_cmpblk, s_hsync_n, s_vsync_n;
    logic       s_line_start, s_frame_start, s_nmi_n;

    video_timing #(
        .H_TOTAL(S_HT), .H_ACTIVE(S_HA), .HS_START(S_HSS), .HS_END(S_HSE),
        .V_TOTAL(S_VT), .V_ACT_START(S_VAS), .V_ACT_END(S_VAE),
        .VS_START(S_VSS), .VS_END(S_VSE)
    ) u_small (
        .clk(clk), .rst(rst_s), .flip_ena(flip_s), .nmi_ena(nmi_s),
        .htiming(s_htiming), .vtiming(s_vtiming), .vtiming_f(s_vtiming_f),
        .flip_lat(s_flip_lat), .hblank(s_hblank), .vblank(s_vblank),
        .cmpblk(s_cmpblk), .hsync_n(s_hsync_n), .vsync_n(s_vsync_n),
        .line_start(s_line_start), .frame_start(s_frame_start), .nmi_n(s_nmi_n)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model of the scaled instance: position is derived from the
    // number of cycles since reset, flip and NMI from event rules.
    longint m_t = 0;
    int     m_h = 0;
    int     m_v = 0;
    bit     m_rst = 1'b1;
    bit     m_flip = 1'b0;
    bit     m_pend = 1'b0;

    always @(posedge clk) begin
        if (rst_s) begin
            m_t = 0; m_rst = 1'b1; m_flip = 1'b0; m_pend = 1'b0;
            m_h = 0; m_v = 0;
        end else begin
            m_t++;
            m_rst = 1'b0;
            m_h = int'(m_t % S_HT);
            m_v = int'((m_t / S_HT) % S_VT);
            if (m_h == 0 && m_v == 0) m_flip = flip_s;
            if (!nmi_s) m_pend = 1'b0;
            else if (m_h == 0 && m_v == S_VAE) m_pend = 1'b1;
        end
    end

    bit auto_en = 1'b0;
    always @(negedge clk) begin
        if (auto_en) begin
            check("s_htiming", s_htiming, m_h);
            check("s_vtiming", s_vtiming, m_v);
            check("s_vtiming_f", s_vtiming_f, (m_v % 256) ^ (m_flip ? 255 : 0));
            check("s_flip_lat", s_flip_lat, m_flip);
            check("s_hblank", s_hblank, m_h >= S_HA);
            check("s_vblank", s_vblank, (m_v < S_VAS) || (m_v >= S_VAE));
            check("s_cmpblk", s_cmpblk, (m_h >= S_HA) || (m_v < S_VAS) || (m_v >= S_VAE));
            check("s_hsync_n", s_hsync_n, !(m_h >= S_HSS && m_h < S_HSE));
            check("s_vsync_n", s_vsync_n, !(m_v >= S_VSS && m_v < S_VSE));
            check("s_line_start", s_line_start, !m_rst && m_h == 0);
            check("s_frame_start", s_frame_start, !m_rst && m_h == 0 && m_v == 0);
            check("s_nmi_n", s_nmi_n, !m_pend);
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic goto_pos(input int h, input int v);
        int n = 0;
        while (!(m_h == h && m_v == v) && n < 2 * S_FRAME) begin
            step();
            n++;
        end
        if (n >= 2 * S_FRAME) begin
            n_checks++;
            n_errors++;
            $display("FAIL goto_timeout: position h=%0d v=%0d never reached", h, v);
        end
    endtask

    typedef struct {
        int   adv;
        int   h;
        int   v;
        logic hb;
        logic cmp;
        logic ls;
        logic hs;
    } bvec_t;

    bvec_t tbl[10];

    initial begin
        int vs_cnt, vs_h, vs_v, vbf_h, vbf_v, vbr_h, vbr_v, nf_h, nf_v;
        int hs_cnt, hs_first, cnt;
        logic prev_vb;

        tbl[0] = '{0,   0,   0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[1] = '{1,   1,   0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{511, 512, 0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{95,  607, 0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{1,   608, 0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{63,  671, 0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1,   672, 0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{95,  767, 0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[8] = '{1,   0,   1, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[9] = '{1,   1,   1, 1'b0, 1'b1, 1'b0, 1'b1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        auto_en = 1'b1;

        // Full-size instance: reset values, then line-level positions
        for (int i = 0; i < 10; i++) begin
            repeat (tbl[i].adv) @(posedge clk);
            if (tbl[i].adv > 0) @(negedge clk);
            check($sformatf("big_h[%0d]", i), b_htiming, tbl[i].h);
            check($sformatf("big_v[%0d]", i), b_vtiming, tbl[i].v);
            check($sformatf("big_hblank[%0d]", i), b_hblank, tbl[i].hb);
            check($sformatf("big_cmpblk[%0d]", i), b_cmpblk, tbl[i].cmp);
            check($sformatf("big_line_start[%0d]", i), b_line_start, tbl[i].ls);
            check($sformatf("big_hsync_n[%0d]", i), b_hsync_n, tbl[i].hs);
            if (i == 0) begin
                check("big_rst_vblank", b_vblank, 1);
                check("big_rst_vsync_n", b_vsync_n, 1);
                check("big_rst_frame_start", b_frame_start, 0);
                check("big_rst_nmi_n", b_nmi_n, 1);
                check("big_rst_flip_lat", b_flip_lat, 0);
                check("big_rst_vtiming_f", b_vtiming_f, 0);
                rst_b = 1'b0;
            end
        end

        // One full line of hsync on the full-size instance
        hs_cnt = 0;
        hs_first = -1;
        for (int i = 0; i < 768; i++) begin
            step();
            if (!b_hsync_n) begin
                if (hs_cnt == 0) hs_first = int'(b_htiming);
                hs_cnt++;
            end
        end
        check("big_hsync_len", hs_cnt, 64);
        check("big_hsync_start", hs_first, 608);

        // Scaled instance: one frame of sync/blank/NMI edges
        rst_s = 1'b0;
        vs_cnt = 0; vs_h = -1; vs_v = -1;
        vbf_h = -1; vbf_v = -1; vbr_h = -1; vbr_v = -1; nf_h = -1; nf_v = -1;
        prev_vb = 1'b1;
        for (int i = 0; i < S_FRAME; i++) begin
            step();
            if (!s_vsync_n) begin
                if (vs_cnt == 0) begin vs_h = int'(s_htiming); vs_v = int'(s_vtiming); end
                vs_cnt++;
            end
            if (prev_vb && !s_vblank) begin vbf_h = int'(s_htiming); vbf_v = int'(s_vtiming); end
            if (!prev_vb && s_vblank) begin vbr_h = int'(s_htiming); vbr_v = int'(s_vtiming); end
            if (!s_nmi_n && nf_v < 0) begin nf_h = int'(s_htiming); nf_v = int'(s_vtiming); end
            prev_vb = s_vblank;
        end
        check("vsync_len", vs_cnt, 2 * S_HT);
        check("vsync_start_v", vs_v, S_VSS);
        check("vsync_start_h", vs_h, 0);
        check("vblank_fall_v", vbf_v, S_VAS);
        check("vblank_fall_h", vbf_h, 0);
        check("vblank_rise_v", vbr_v, S_VAE);
        check("vblank_rise_h", vbr_h, 0);
        check("nmi_fall_v", nf_v, S_VAE);
        check("nmi_fall_h", nf_h, 0);

        // NMI acknowledge and edge behaviour
        goto_pos(0, S_VSS);
        check("nmi_pending", s_nmi_n, 0);
        nmi_s = 1'b0;
        step();
        check("nmi_ack", s_nmi_n, 1);
        goto_pos(0, S_VSS + 1);
        nmi_s = 1'b1;
        cnt = 0;
        for (int i = 0; i < 2 * S_FRAME && !(m_h == 0 && m_v == S_VAE); i++) begin
            if (!s_nmi_n) cnt++;
            step();
        end
        check("nmi_no_retrigger", cnt, 0);
        check("nmi_next_frame", s_nmi_n, 0);

        // Flip request mid-frame takes effect only at the next frame
        goto_pos(0, 10);
        flip_s = 1'b1;
        cnt = 0;
        for (int i = 0; i < 2 * S_FRAME && !(m_h == 0 && m_v == 0); i++) begin
            if (int'(s_vtiming_f) != (m_v % 256)) cnt++;
            step();
        end
        check("flip_deferred", cnt, 0);
        check("flip_frame_vf", s_vtiming_f, 8'hFF);
        check("flip_frame_lat", s_flip_lat, 1);
        goto_pos(0, S_VAS);
        check("flip_active_vf", s_vtiming_f, 8'hFF ^ S_VAS);

        // Mask drop on the exact vblank-rise cycle while pending
        goto_pos(S_HT - 1, S_VAE - 1);
        check("nmi_pend_before_clear", s_nmi_n, 0);
        nmi_s = 1'b0;
        step();
        check("nmi_clear_wins", s_nmi_n, 1);
        nmi_s = 1'b1;
        cnt = 0;
        for (int i = 0; i < S_FRAME - 1; i++) begin
            step();
            if (!s_nmi_n) cnt++;
        end
        check("nmi_quiet_frame", cnt, 0);
        step();
        check("nmi_rearm", s_nmi_n, 0);

        // Reset mid-operation with NMI pending and flip latched
        goto_pos(0, S_VAE + 2);
        check("pre_rst_nmi_n", s_nmi_n, 0);
        check("pre_rst_flip", s_flip_lat, 1);
        rst_s = 1'b1;
        step();
        check("rst_nmi_n", s_nmi_n, 1);
        check("rst_flip_lat", s_flip_lat, 0);
        check("rst_htiming", s_htiming, 0);
        check("rst_vtiming", s_vtiming, 0);
        rst_s = 1'b0;

        // Randomized control activity against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) flip_s = ~flip_s;
            if ($urandom_range(0, 39) == 0) nmi_s = ~nmi_s;
            rst_s = ($urandom_range(0, 799) == 0);
            step();
        end

        auto_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
